// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator with a registered colour/sync output stage (optional FRAME_COUNTER_EN frame counter).
// Latency: colPos/rowPos -> RGB/hsync/vsync pins is one clock; frameTick is registered and aligned with (0, V_VISIBLE).
// Backpressure: none; free-running from the pixel clock, only reset stalls it.
module vga_controller #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] colPos,
  output logic [9:0] rowPos,
  output logic       on,
  input  logic [5:0] colorIn,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       frameTick
`ifdef FRAME_COUNTER_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_PRE    = 10'(V_VISIBLE - 1);

  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hsRaw;
  logic       vsRaw;
  logic       lineEnd;
  logic       tickNext;

  assign colPos   = hCount;
  assign rowPos   = vCount;
  assign on       = (hCount < H_VIS) && (vCount < V_VIS) && !reset;
  assign hsRaw    = (hCount >= HS_START) && (hCount <= HS_END);
  assign vsRaw    = (vCount >= VS_START) && (vCount <= VS_END);
  assign lineEnd  = (hCount == H_LAST);
  // Registered so the pulse lands in the clock whose counters read (0, V_VISIBLE).
  assign tickNext = lineEnd && (vCount == V_PRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hCount    <= '0;
      vCount    <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
      frameTick <= 1'b0;
    end else begin
      hCount <= lineEnd ? '0 : hCount + 10'd1;
      if (lineEnd) begin
        vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end
      {red, green, blue} <= on ? colorIn : 6'd0;
      hsync     <= hsRaw ? SYNC_POL : ~SYNC_POL;
      vsync     <= vsRaw ? SYNC_POL : ~SYNC_POL;
      frameTick <= tickNext;
    end
  end

`ifdef FRAME_COUNTER_EN
  // Steps on the same edge that raises frameTick; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      frameCount <= '0;
    end else if (tickNext) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`endif

endmodule
